// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM burst streamer.
//   state_t      : controller states (IDLE, RUN)
//   DEF_ADDR_W   : default ROM address width
//   DEF_DATA_W   : default ROM data / stream byte width
//   DEF_ROM_LAST : default highest valid ROM address (wraps to 0 after it)
package rom_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ROM_LAST = 20000;

endpackage

// File: rtl/rom_streamer.sv
// Streams a burst of bytes out of an external combinational-read ROM onto a
// valid/ready byte stream.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request a burst (only looked at while idle)
//   base_addr       : first ROM address of the burst
//   length          : number of bytes in the burst (0 = immediate done)
//   abort           : cancel the current burst, no done pulse
//   rom_addr        : ROM address (always the current address register)
//   rom_ce/rom_rd_en: asserted only in cycles where a byte is fetched
//   rom_data        : combinational ROM read data
//   out_data/out_valid/out_last/out_ready : output byte stream
//   busy            : controller is not idle
//   done            : one-cycle pulse when a burst completes normally
module rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROM_LAST = DEF_ROM_LAST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_LAST);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remaining_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              done_reg;

  logic fetch;
  logic xfer;

  // A byte is read whenever bytes are still owed and the single output
  // register is empty or being emptied this cycle.
  assign fetch = (state_reg == RUN) && (remaining_reg != '0) &&
                 (!out_valid_reg || out_ready);
  assign xfer  = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        // Address and last data byte are deliberately left as they are.
        state_reg     <= IDLE;
        remaining_reg <= '0;
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else if (state_reg == IDLE) begin
        if (start) begin
          addr_reg      <= base_addr;
          remaining_reg <= length;
          if (length != '0) begin
            state_reg <= RUN;
          end else begin
            done_reg <= 1'b1;
          end
        end
      end else begin
        if (fetch) begin
          out_data_reg  <= rom_data;
          out_valid_reg <= 1'b1;
          out_last_reg  <= (remaining_reg == ADDR_W'(1));
          remaining_reg <= remaining_reg - 1'b1;
          addr_reg      <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
        end else if (xfer) begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
        // The last byte leaves with remaining already 0, so no fetch can
        // collide with this completion.
        if (xfer && out_last_reg) begin
          state_reg <= IDLE;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign rom_addr  = addr_reg;
  assign rom_ce    = fetch;
  assign rom_rd_en = fetch;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_rom_streamer.sv
module tb_rom_streamer;

  localparam int ROM_LAST = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        abort;
  logic [15:0] rom_addr;
  logic        rom_ce;
  logic        rom_rd_en;
  logic [7:0]  rom_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ROM contents: mem[a] = a[7:0]
  assign rom_data = rom_addr[7:0];

  rom_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_ce    (rom_ce),
    .rom_rd_en (rom_rd_en),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Reference: the i-th byte of a burst comes from (base + i) modulo ROM size.
  function automatic int exp_addr(input int b, input int i);
    return (b + i) % (ROM_LAST + 1);
  endfunction

  task automatic check_idle_outputs(input string tag);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL %s out_last got %b want 0", tag, out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy got %b want 0", tag, busy); end
    n_cmp++; if (rom_ce !== 1'b0 || rom_rd_en !== 1'b0) begin n_bad++; $display("FAIL %s rom_ce/rd_en got %b/%b want 0/0", tag, rom_ce, rom_rd_en); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = 16'h0; length = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    n_cmp++; if (rom_addr !== 16'h0) begin n_bad++; $display("FAIL reset rom_addr got %h want 0000", rom_addr); end
    n_cmp++; if (out_data !== 8'h0) begin n_bad++; $display("FAIL reset out_data got %h want 00", out_data); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b want 0", done); end
    @(posedge clk); #1 rst = 1'b0;
    $display("reset: checked");
  endtask

  // mode 0: ready always 1; 1: ready toggles; 2: random ready plus stray starts.
  // abort_at >= 0 aborts once that many bytes have been transferred.
  task automatic run_burst(input string tag, input int b, input int len,
                           input int mode, input int abort_at);
    int  xfer_idx = 0;
    int  fetch_idx = 0;
    bit  fin = 1'b0;
    bit  ended = 1'b0;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h0;
    logic       prev_last = 1'b0;
    int  ea;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'(b); length = 16'(len); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < len * 4 + 20; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      abort = 1'b0; start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && !fin && $urandom_range(0, 3) == 0) begin
        start = 1'b1; base_addr = 16'($urandom); length = 16'($urandom);
      end
      if (!fin && xfer_idx == abort_at) begin
        abort = 1'b1; out_ready = 1'b0;
      end
      @(negedge clk);
      n_cmp++; if (rom_ce !== rom_rd_en) begin n_bad++; $display("FAIL %s ce/rd_en differ %b/%b", tag, rom_ce, rom_rd_en); end
      if (fin) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s done got %b want 1", tag, done); end
        check_idle_outputs(tag);
        n_cmp++; if (fetch_idx !== len) begin n_bad++; $display("FAIL %s fetch count got %0d want %0d", tag, fetch_idx, len); end
        if (mode == 0) begin
          n_cmp++; if (cyc !== len + 1) begin n_bad++; $display("FAIL %s done cycle got %0d want %0d", tag, cyc, len + 1); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s done pulse too long got %b want 0", tag, done); end
        ended = 1'b1;
        break;
      end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL %s done/busy got %b/%b want 0/1", tag, done, busy); end
      if (rom_ce) begin
        ea = exp_addr(b, fetch_idx);
        n_cmp++; if (rom_addr !== 16'(ea)) begin n_bad++; $display("FAIL %s rom_addr[%0d] got %0d want %0d", tag, fetch_idx, rom_addr, ea); end
        fetch_idx++;
      end
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_bad++; $display("FAIL %s stall hold got v=%b d=%h l=%b want v=1 d=%h l=%b", tag, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++; if (rom_ce !== 1'b0) begin n_bad++; $display("FAIL %s fetch while stalled got rom_ce=%b want 0", tag, rom_ce); end
      end
      if (out_valid && out_ready) begin
        ea = exp_addr(b, xfer_idx);
        n_cmp++; if (out_data !== 8'(ea)) begin n_bad++; $display("FAIL %s byte[%0d] got %h want %h", tag, xfer_idx, out_data, 8'(ea)); end
        n_cmp++; if (out_last !== (xfer_idx == len - 1)) begin n_bad++; $display("FAIL %s last[%0d] got %b want %b", tag, xfer_idx, out_last, (xfer_idx == len - 1)); end
        xfer_idx++;
        if (xfer_idx == len) fin = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (abort) begin
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s abort done got %b want 0", tag, done); end
        check_idle_outputs(tag);
        ended = 1'b1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (!ended) begin n_bad++; $display("FAIL %s timeout got %0d transfers want %0d", tag, xfer_idx, len); end
    $display("burst %s: base=%0d len=%0d mode=%0d transfers=%0d", tag, b, len, mode, xfer_idx);
  endtask

  task automatic test_basic;
    run_burst("basic", 16'h0010, 4, 0, -1);
  endtask

  task automatic test_stall;
    run_burst("stall", 0, 3, 1, -1);
  endtask

  task automatic test_wrap;
    run_burst("wrap", 19999, 3, 0, -1);
  endtask

  task automatic test_zero_length;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h1234; length = 16'h0; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_len done got %b want 1", done); end
    check_idle_outputs("zero_len");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_len extra done got %b want 0", done); end
      check_idle_outputs("zero_len_hold");
    end
    $display("zero_len: checked");
  endtask

  task automatic test_abort;
    run_burst("abort", 16'h0020, 8, 0, 2);
    run_burst("after_abort", 16'h0030, 4, 0, -1);
  endtask

  task automatic test_start_abort_idle;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; base_addr = 16'h0050; length = 16'd5;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL start_abort done got %b want 0", done); end
      check_idle_outputs("start_abort");
      @(posedge clk);
    end
    $display("start_abort: checked");
  endtask

  task automatic test_rst_mid;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0040; length = 16'd8; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin n_bad++; $display("FAIL rst_mid pre v/d got %b/%h want 1/40", out_valid, out_data); end
    @(posedge clk); #1 rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    n_cmp++; if (rom_addr !== 16'h0 || out_data !== 8'h0 || done !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid addr/data/done got %h/%h/%b want 0000/00/0", rom_addr, out_data, done);
    end
    $display("rst_mid: checked");
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      run_burst("random", int'($urandom_range(0, ROM_LAST)), int'($urandom_range(1, 20)), 2, -1);
    end
  endtask

  task automatic test_long_wrap;
    run_burst("long_wrap", ROM_LAST - 5, ROM_LAST + 10, 0, -1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_zero_length;
    test_abort;
    test_start_abort_idle;
    test_rst_mid;
    test_random;
    test_long_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
